// File: rtl/sram_arbiter.sv
// Two-port arbiter for the external 256Kx8 SRAM: sequences setup/strobe/hold and alternates priority on ties.
// Optional CPU write protection of WP_BASE..WP_TOP is enabled by defining SRAM_ARB_WPROT_EN.
module sram_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter logic [17:0] WP_BASE       = 18'h0C000,
  parameter logic [17:0] WP_TOP        = 18'h0FFFF
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        cpu_req_i,
  input  logic        cpu_rnw_i,
  input  logic [17:0] cpu_addr_i,
  input  logic [7:0]  cpu_wdata_i,
  output logic [7:0]  cpu_rdata_o,
  output logic        cpu_done_o,
  output logic        cpu_ovf_o,
  input  logic        dma_req_i,
  input  logic        dma_rnw_i,
  input  logic [17:0] dma_addr_i,
  input  logic [7:0]  dma_wdata_i,
  output logic [7:0]  dma_rdata_o,
  output logic        dma_ack_o,
  output logic        ram_cs_b_o,
  output logic        ram_oe_b_o,
  output logic        ram_we_b_o,
  output logic [17:0] ram_a_o,
  output logic [7:0]  ram_dout_o,
  output logic        ram_doe_o,
  input  logic [7:0]  ram_din_i
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam logic [2:0] LAST_STROBE = 3'(ACCESS_CYCLES - 1);
`ifdef SRAM_ARB_WPROT_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif

  state_t      state_q;
  logic [2:0]  cnt_q;
  logic        last_dma_q;
  logic        cpu_pend_q;
  logic        slot_rnw_q;
  logic [17:0] slot_addr_q;
  logic [7:0]  slot_wdata_q;
  logic        acc_dma_q;
  logic        acc_rnw_q;
  logic        acc_wp_q;

  logic        decide_s;
  logic        cpu_avail_s;
  logic        dma_avail_s;
  logic        grant_cpu_s;
  logic        grant_dma_s;
  logic        nxt_rnw_s;
  logic [17:0] nxt_addr_s;
  logic [7:0]  nxt_wdata_s;
  logic        in_wp_s;
  logic        nxt_wp_s;

  // Arbitration and selection of the next access; a new access can start from IDLE or straight out of HOLD.
  always_comb begin
    decide_s    = (state_q == ST_IDLE) || (state_q == ST_HOLD);
    cpu_avail_s = cpu_pend_q || cpu_req_i;
    // A DMA master still holds dma_req during its own ack cycle, so ignore it there.
    dma_avail_s = dma_req_i && !((state_q == ST_HOLD) && acc_dma_q);
    grant_cpu_s = 1'b0;
    grant_dma_s = 1'b0;
    if (decide_s) begin
      if (cpu_avail_s && (!dma_avail_s || last_dma_q)) begin
        grant_cpu_s = 1'b1;
      end else if (dma_avail_s) begin
        grant_dma_s = 1'b1;
      end else begin
        grant_cpu_s = 1'b0;
      end
    end else begin
      grant_dma_s = 1'b0;
    end

    if (grant_dma_s) begin
      nxt_rnw_s   = dma_rnw_i;
      nxt_addr_s  = dma_addr_i;
      nxt_wdata_s = dma_wdata_i;
    end else if (cpu_pend_q) begin
      nxt_rnw_s   = slot_rnw_q;
      nxt_addr_s  = slot_addr_q;
      nxt_wdata_s = slot_wdata_q;
    end else begin
      nxt_rnw_s   = cpu_rnw_i;
      nxt_addr_s  = cpu_addr_i;
      nxt_wdata_s = cpu_wdata_i;
    end

    in_wp_s  = (nxt_addr_s >= WP_BASE) && (nxt_addr_s <= WP_TOP);
    nxt_wp_s = WP_EN && grant_cpu_s && !nxt_rnw_s && in_wp_s;
  end

  // Pending CPU slot, access sequencer and registered SRAM pin drive.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 3'd0;
      last_dma_q   <= 1'b1;
      cpu_pend_q   <= 1'b0;
      slot_rnw_q   <= 1'b0;
      slot_addr_q  <= 18'd0;
      slot_wdata_q <= 8'd0;
      acc_dma_q    <= 1'b0;
      acc_rnw_q    <= 1'b0;
      acc_wp_q     <= 1'b0;
      cpu_rdata_o  <= 8'd0;
      cpu_done_o   <= 1'b0;
      cpu_ovf_o    <= 1'b0;
      dma_rdata_o  <= 8'd0;
      dma_ack_o    <= 1'b0;
      ram_cs_b_o   <= 1'b1;
      ram_oe_b_o   <= 1'b1;
      ram_we_b_o   <= 1'b1;
      ram_a_o      <= 18'd0;
      ram_dout_o   <= 8'd0;
      ram_doe_o    <= 1'b0;
    end else begin
      cpu_done_o <= 1'b0;
      dma_ack_o  <= 1'b0;

      // A request arriving while the slot is being granted refills it without counting as an overrun.
      if (grant_cpu_s && cpu_pend_q) begin
        cpu_pend_q <= cpu_req_i;
        if (cpu_req_i) begin
          slot_rnw_q   <= cpu_rnw_i;
          slot_addr_q  <= cpu_addr_i;
          slot_wdata_q <= cpu_wdata_i;
        end
      end else if (cpu_req_i && !grant_cpu_s) begin
        cpu_pend_q   <= 1'b1;
        slot_rnw_q   <= cpu_rnw_i;
        slot_addr_q  <= cpu_addr_i;
        slot_wdata_q <= cpu_wdata_i;
        if (cpu_pend_q) begin
          cpu_ovf_o <= 1'b1;
        end
      end

      case (state_q)
        ST_IDLE, ST_HOLD: begin
          if (grant_cpu_s || grant_dma_s) begin
            state_q    <= ST_SETUP;
            last_dma_q <= grant_dma_s;
            acc_dma_q  <= grant_dma_s;
            acc_rnw_q  <= nxt_rnw_s;
            acc_wp_q   <= nxt_wp_s;
            ram_a_o    <= nxt_addr_s;
            ram_cs_b_o <= 1'b0;
            ram_we_b_o <= 1'b1;
            ram_oe_b_o <= !nxt_rnw_s;
            if (nxt_rnw_s) begin
              ram_doe_o <= 1'b0;
            end else begin
              ram_doe_o  <= !nxt_wp_s;
              ram_dout_o <= nxt_wdata_s;
            end
          end else begin
            state_q    <= ST_IDLE;
            ram_cs_b_o <= 1'b1;
            ram_oe_b_o <= 1'b1;
            ram_we_b_o <= 1'b1;
            ram_doe_o  <= 1'b0;
          end
        end
        ST_SETUP: begin
          state_q    <= ST_STROBE;
          cnt_q      <= 3'd0;
          ram_we_b_o <= acc_rnw_q || acc_wp_q;
        end
        ST_STROBE: begin
          if (cnt_q == LAST_STROBE) begin
            state_q    <= ST_HOLD;
            ram_we_b_o <= 1'b1;
            ram_oe_b_o <= 1'b1;
            if (acc_dma_q) begin
              dma_ack_o <= 1'b1;
              if (acc_rnw_q) begin
                dma_rdata_o <= ram_din_i;
              end
            end else begin
              cpu_done_o <= 1'b1;
              if (acc_rnw_q) begin
                cpu_rdata_o <= ram_din_i;
              end
            end
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter with a behavioural SRAM model.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_rnw = 1'b0;
  logic [17:0] cpu_addr = 18'd0;
  logic [7:0]  cpu_wdata = 8'd0;
  logic [7:0]  cpu_rdata;
  logic        cpu_done;
  logic        cpu_ovf;
  logic        dma_req = 1'b0;
  logic        dma_rnw = 1'b0;
  logic [17:0] dma_addr = 18'd0;
  logic [7:0]  dma_wdata = 8'd0;
  logic [7:0]  dma_rdata;
  logic        dma_ack;
  logic        ram_cs_b;
  logic        ram_oe_b;
  logic        ram_we_b;
  logic [17:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_doe;
  logic [7:0]  ram_din;

  logic [7:0]  mem [0:262143];

  int n_cmp = 0;
  int n_bad = 0;

  sram_arbiter dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .cpu_req_i   (cpu_req),
    .cpu_rnw_i   (cpu_rnw),
    .cpu_addr_i  (cpu_addr),
    .cpu_wdata_i (cpu_wdata),
    .cpu_rdata_o (cpu_rdata),
    .cpu_done_o  (cpu_done),
    .cpu_ovf_o   (cpu_ovf),
    .dma_req_i   (dma_req),
    .dma_rnw_i   (dma_rnw),
    .dma_addr_i  (dma_addr),
    .dma_wdata_i (dma_wdata),
    .dma_rdata_o (dma_rdata),
    .dma_ack_o   (dma_ack),
    .ram_cs_b_o  (ram_cs_b),
    .ram_oe_b_o  (ram_oe_b),
    .ram_we_b_o  (ram_we_b),
    .ram_a_o     (ram_a),
    .ram_dout_o  (ram_dout),
    .ram_doe_o   (ram_doe),
    .ram_din_i   (ram_din)
  );

  always #5 clk = ~clk;

  // SRAM model: writes while CS and WE are low with the pin driver enabled.
  always @(posedge clk) begin
    if (!ram_cs_b && !ram_we_b && ram_doe) mem[ram_a] <= ram_dout;
  end
  assign ram_din = mem[ram_a];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_issue(input logic rnw, input logic [17:0] a, input logic [7:0] d);
    cpu_req = 1'b1; cpu_rnw = rnw; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic dma_issue(input logic rnw, input logic [17:0] a, input logic [7:0] d);
    dma_req = 1'b1; dma_rnw = rnw; dma_addr = a; dma_wdata = d;
  endtask

  // Runs n cycles, recording when done/ack first appear (1 = first cycle after the request edge).
  task automatic run(input int n, output int c_done, output int d_ack, output int n_done,
                     output int we_low, output int doe_hi, output logic [7:0] c_rd, output logic [7:0] d_rd);
    c_done = 0; d_ack = 0; n_done = 0; we_low = 0; doe_hi = 0; c_rd = 8'h00; d_rd = 8'h00;
    for (int c = 1; c <= n; c++) begin
      tick();
      cpu_req = 1'b0;
      if (ram_we_b === 1'b0) we_low++;
      if (ram_doe === 1'b1) doe_hi++;
      if (cpu_done === 1'b1) begin
        n_done++;
        if (c_done == 0) c_done = c;
        c_rd = cpu_rdata;
      end
      if (dma_ack === 1'b1) begin
        if (d_ack == 0) d_ack = c;
        d_rd = dma_rdata;
        dma_req = 1'b0;
      end
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    n_cmp++; if (ram_cs_b !== 1'b1) begin n_bad++; $display("FAIL reset_cs_b got %b want 1", ram_cs_b); end
    n_cmp++; if (ram_oe_b !== 1'b1) begin n_bad++; $display("FAIL reset_oe_b got %b want 1", ram_oe_b); end
    n_cmp++; if (ram_we_b !== 1'b1) begin n_bad++; $display("FAIL reset_we_b got %b want 1", ram_we_b); end
    n_cmp++; if (ram_a !== 18'd0) begin n_bad++; $display("FAIL reset_a got %h want 0", ram_a); end
    n_cmp++; if (ram_dout !== 8'd0) begin n_bad++; $display("FAIL reset_dout got %h want 0", ram_dout); end
    n_cmp++; if (ram_doe !== 1'b0) begin n_bad++; $display("FAIL reset_doe got %b want 0", ram_doe); end
    n_cmp++; if (cpu_ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b want 0", cpu_ovf); end
    n_cmp++; if ({cpu_done, dma_ack} !== 2'b00) begin n_bad++; $display("FAIL reset_pulses got %b want 00", {cpu_done, dma_ack}); end
    n_cmp++; if ({cpu_rdata, dma_rdata} !== 16'h0000) begin n_bad++; $display("FAIL reset_rdata got %h want 0000", {cpu_rdata, dma_rdata}); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    int cd, da, nd, wl, dh;
    logic [7:0] crd, drd;
    cpu_issue(1'b0, 18'h00123, 8'hA5);
    run(8, cd, da, nd, wl, dh, crd, drd);
    n_cmp++; if (cd !== 4) begin n_bad++; $display("FAIL wr_done_cycle got %0d want 4", cd); end
    n_cmp++; if (wl !== 2) begin n_bad++; $display("FAIL wr_we_low got %0d want 2", wl); end
    n_cmp++; if (dh !== 4) begin n_bad++; $display("FAIL wr_doe_cycles got %0d want 4", dh); end
    n_cmp++; if (mem[18'h00123] !== 8'hA5) begin n_bad++; $display("FAIL wr_mem got %h want a5", mem[18'h00123]); end
    cpu_issue(1'b1, 18'h00123, 8'h00);
    run(8, cd, da, nd, wl, dh, crd, drd);
    n_cmp++; if (cd !== 4) begin n_bad++; $display("FAIL rd_done_cycle got %0d want 4", cd); end
    n_cmp++; if (crd !== 8'hA5) begin n_bad++; $display("FAIL rd_data got %h want a5", crd); end
    n_cmp++; if (wl !== 0 || dh !== 0) begin n_bad++; $display("FAIL rd_no_drive got we=%0d doe=%0d want 0 0", wl, dh); end
    n_cmp++; if (cpu_rdata !== 8'hA5) begin n_bad++; $display("FAIL rd_data_held got %h want a5", cpu_rdata); end
  endtask

  task automatic test_tie();
    int cd, da, nd, wl, dh;
    logic [7:0] crd, drd;
    apply_reset();
    tick();
    cpu_issue(1'b0, 18'h00200, 8'h11);
    dma_issue(1'b0, 18'h02900, 8'h3C);
    run(12, cd, da, nd, wl, dh, crd, drd);
    n_cmp++; if (cd !== 4) begin n_bad++; $display("FAIL tie1_cpu_done got %0d want 4", cd); end
    n_cmp++; if (da !== 8) begin n_bad++; $display("FAIL tie1_dma_ack got %0d want 8", da); end
    n_cmp++; if (mem[18'h02900] !== 8'h3C) begin n_bad++; $display("FAIL tie1_dma_mem got %h want 3c", mem[18'h02900]); end
    n_cmp++; if (mem[18'h00200] !== 8'h11) begin n_bad++; $display("FAIL tie1_cpu_mem got %h want 11", mem[18'h00200]); end
    cpu_issue(1'b1, 18'h00123, 8'h00);
    run(6, cd, da, nd, wl, dh, crd, drd);
    n_cmp++; if (crd !== 8'hA5) begin n_bad++; $display("FAIL tie_mid_rd got %h want a5", crd); end
    cpu_issue(1'b1, 18'h00200, 8'h00);
    dma_issue(1'b1, 18'h02900, 8'h00);
    run(12, cd, da, nd, wl, dh, crd, drd);
    n_cmp++; if (da !== 4) begin n_bad++; $display("FAIL tie2_dma_ack got %0d want 4", da); end
    n_cmp++; if (drd !== 8'h3C) begin n_bad++; $display("FAIL tie2_dma_rdata got %h want 3c", drd); end
    n_cmp++; if (cd !== 8) begin n_bad++; $display("FAIL tie2_cpu_done got %0d want 8", cd); end
    n_cmp++; if (crd !== 8'h11) begin n_bad++; $display("FAIL tie2_cpu_rdata got %h want 11", crd); end
  endtask

  task automatic test_overrun();
    int cd, da, nd, wl, dh;
    logic [7:0] crd, drd;
    dma_issue(1'b0, 18'h00300, 8'h5A);
    tick();
    cpu_issue(1'b0, 18'h00400, 8'h66);
    tick();
    cpu_req = 1'b0;
    n_cmp++; if (cpu_ovf !== 1'b0) begin n_bad++; $display("FAIL ovr_first_ovf got %b want 0", cpu_ovf); end
    tick();
    cpu_issue(1'b0, 18'h00401, 8'h77);
    tick();
    cpu_req = 1'b0;
    n_cmp++; if (dma_ack !== 1'b1) begin n_bad++; $display("FAIL ovr_dma_ack got %b want 1", dma_ack); end
    dma_req = 1'b0;
    n_cmp++; if (cpu_ovf !== 1'b1) begin n_bad++; $display("FAIL ovr_ovf got %b want 1", cpu_ovf); end
    run(10, cd, da, nd, wl, dh, crd, drd);
    n_cmp++; if (cd !== 4 || nd !== 1) begin n_bad++; $display("FAIL ovr_done got at=%0d n=%0d want 4 1", cd, nd); end
    n_cmp++; if (mem[18'h00401] !== 8'h77) begin n_bad++; $display("FAIL ovr_second_mem got %h want 77", mem[18'h00401]); end
    n_cmp++; if (mem[18'h00400] === 8'h66) begin n_bad++; $display("FAIL ovr_first_mem got %h want not 66", mem[18'h00400]); end
    n_cmp++; if (mem[18'h00300] !== 8'h5A) begin n_bad++; $display("FAIL ovr_dma_mem got %h want 5a", mem[18'h00300]); end
    n_cmp++; if (cpu_ovf !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky got %b want 1", cpu_ovf); end
  endtask

  task automatic test_reset_mid_write();
    int cd, da, nd, wl, dh;
    logic [7:0] crd, drd;
    cpu_issue(1'b0, 18'h00500, 8'h99);
    tick();
    cpu_req = 1'b0;
    tick();
    n_cmp++; if (ram_we_b !== 1'b0) begin n_bad++; $display("FAIL rmid_strobe_we got %b want 0", ram_we_b); end
    reset_n = 1'b0;
    tick();
    n_cmp++; if ({ram_cs_b, ram_we_b, ram_oe_b, ram_doe} !== 4'b1110) begin
      n_bad++; $display("FAIL rmid_pins got %b want 1110", {ram_cs_b, ram_we_b, ram_oe_b, ram_doe});
    end
    n_cmp++; if (cpu_ovf !== 1'b0) begin n_bad++; $display("FAIL rmid_ovf got %b want 0", cpu_ovf); end
    tick();
    reset_n = 1'b1;
    run(8, cd, da, nd, wl, dh, crd, drd);
    n_cmp++; if (nd !== 0 || wl !== 0) begin n_bad++; $display("FAIL rmid_abandon got done=%0d we=%0d want 0 0", nd, wl); end
  endtask

  task automatic test_wprot();
    int cd, da, nd, wl, dh;
    logic [7:0] crd, drd;
    cpu_issue(1'b0, 18'h0C000, 8'hFF);
    run(8, cd, da, nd, wl, dh, crd, drd);
    n_cmp++; if (cd !== 4) begin n_bad++; $display("FAIL wp_cpu_done got %0d want 4", cd); end
`ifdef SRAM_ARB_WPROT_EN
    n_cmp++; if (wl !== 0 || dh !== 0) begin n_bad++; $display("FAIL wp_cpu_blocked got we=%0d doe=%0d want 0 0", wl, dh); end
    dma_issue(1'b0, 18'h0C000, 8'hFF);
    run(8, cd, da, nd, wl, dh, crd, drd);
    n_cmp++; if (da !== 4 || wl !== 2) begin n_bad++; $display("FAIL wp_dma_write got ack=%0d we=%0d want 4 2", da, wl); end
    n_cmp++; if (mem[18'h0C000] !== 8'hFF) begin n_bad++; $display("FAIL wp_dma_mem got %h want ff", mem[18'h0C000]); end
`else
    n_cmp++; if (wl !== 2) begin n_bad++; $display("FAIL wp_off_we got %0d want 2", wl); end
    n_cmp++; if (mem[18'h0C000] !== 8'hFF) begin n_bad++; $display("FAIL wp_off_mem got %h want ff", mem[18'h0C000]); end
`endif
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_tie();
    test_overrun();
    test_reset_mid_write();
    test_wprot();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
